// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, base opcodes and data-register selection.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR        = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR        = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_e;

  // Base opcodes; zero-extended to the configured IR width. BYPASS is all-ones.
  localparam logic [3:0] OP_SAMPLE   = 4'h1;
  localparam logic [3:0] OP_EXTEST   = 4'h2;
  localparam logic [3:0] OP_INTEST   = 4'h3;
  localparam logic [3:0] OP_CLAMP    = 4'h5;
  localparam logic [3:0] OP_IDCODE   = 4'h7;
  localparam logic [3:0] OP_USERCODE = 4'h8;
  localparam logic [3:0] OP_HIGHZ    = 4'h9;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_ID     = 2'd1,
    DR_BSR    = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; exposes both the current and next state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e TAP_STATE,
  output tap_state_e TAP_NEXT
);

  tap_state_e state_q, state_d;

  always_ff @(posedge TCK) begin
    // NOTE: non-blocking so the register samples the pre-edge next-state value.
    if (!TRST) state_q <= TEST_LOGIC_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so no branch can leave state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = TMS ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = TMS ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = TMS ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = TMS ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  assign TAP_STATE = state_q;
  assign TAP_NEXT  = state_d;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP with instruction register, BYPASS/IDCODE/USERCODE and boundary-scan
// registers, plus the pad/core boundary muxing driven by the current instruction.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned BSR_WIDTH    = 8,
  parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
  parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 TMS,
  input  logic                 TDI,
  output logic                 TDO,
  output logic                 TDO_EN,
  input  logic [BSR_WIDTH-1:0] PIN_IN,
  input  logic [BSR_WIDTH-1:0] CORE_OUT,
  output logic [BSR_WIDTH-1:0] PIN_OUT,
  output logic                 PIN_OE,
  output logic [BSR_WIDTH-1:0] CORE_IN,
  output logic [IR_WIDTH-1:0]  JTAG_IR,
  output logic [3:0]           TAP_STATE
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e state, state_next;

  jtag_tap_fsm u_fsm (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .TAP_STATE (state),
    .TAP_NEXT  (state_next)
  );

  logic [IR_WIDTH-1:0]  ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]  ir_q, ir_d;
  logic                 byp_q, byp_d;
  logic [31:0]          id_sr_q, id_sr_d;
  logic [BSR_WIDTH-1:0] bsr_sr_q, bsr_sr_d;
  logic [BSR_WIDTH-1:0] bsr_upd_q, bsr_upd_d;

  // Instruction decode; anything not matched here behaves as BYPASS.
  logic is_sample, is_extest, is_intest, is_clamp, is_idcode, is_usercode, is_highz, is_bsr;
  assign is_sample   = (ir_q == IR_WIDTH'(OP_SAMPLE));
  assign is_extest   = (ir_q == IR_WIDTH'(OP_EXTEST));
  assign is_intest   = (ir_q == IR_WIDTH'(OP_INTEST));
  assign is_clamp    = (ir_q == IR_WIDTH'(OP_CLAMP));
  assign is_idcode   = (ir_q == IR_IDCODE);
  assign is_usercode = (ir_q == IR_WIDTH'(OP_USERCODE));
  assign is_highz    = (ir_q == IR_WIDTH'(OP_HIGHZ));
  assign is_bsr      = is_sample | is_extest | is_intest;

  dr_sel_e dr_sel;
  always_comb begin
    dr_sel = DR_BYPASS;
    if (is_idcode || is_usercode) dr_sel = DR_ID;
    else if (is_bsr)              dr_sel = DR_BSR;
  end

  always_comb begin
    ir_sr_d   = ir_sr_q;
    ir_d      = ir_q;
    byp_d     = byp_q;
    id_sr_d   = id_sr_q;
    bsr_sr_d  = bsr_sr_q;
    bsr_upd_d = bsr_upd_q;
    case (state)
      CAPTURE_IR: ir_sr_d = IR_CAPTURE;
      SHIFT_IR:   ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      UPDATE_IR:  ir_d    = ir_sr_q;
      CAPTURE_DR: begin
        byp_d = 1'b0;
        case (dr_sel)
          DR_ID:   id_sr_d  = is_idcode ? IDCODE_VAL : USERCODE_VAL;
          DR_BSR:  bsr_sr_d = is_intest ? CORE_OUT : PIN_IN;
          default: ;
        endcase
      end
      SHIFT_DR: begin
        case (dr_sel)
          DR_ID:   id_sr_d  = {TDI, id_sr_q[31:1]};
          DR_BSR:  bsr_sr_d = {TDI, bsr_sr_q[BSR_WIDTH-1:1]};
          default: byp_d    = TDI;
        endcase
      end
      UPDATE_DR: if (is_bsr) bsr_upd_d = bsr_sr_q;
      default: ;
    endcase
    // Walking into Test-Logic-Reset via TMS restores IDCODE on the same edge as TRST would.
    if (state_next == TEST_LOGIC_RESET) ir_d = IR_IDCODE;
  end

  always_ff @(posedge TCK) begin
    if (!TRST) begin
      ir_sr_q   <= '0;
      ir_q      <= IR_IDCODE;
      byp_q     <= 1'b0;
      id_sr_q   <= '0;
      bsr_sr_q  <= '0;
      bsr_upd_q <= '0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      ir_q      <= ir_d;
      byp_q     <= byp_d;
      id_sr_q   <= id_sr_d;
      bsr_sr_q  <= bsr_sr_d;
      bsr_upd_q <= bsr_upd_d;
    end
  end

  always_comb begin
    TDO    = 1'b0;
    TDO_EN = 1'b0;
    if (state == SHIFT_IR) begin
      TDO    = ir_sr_q[0];
      TDO_EN = 1'b1;
    end else if (state == SHIFT_DR) begin
      TDO_EN = 1'b1;
      case (dr_sel)
        DR_ID:   TDO = id_sr_q[0];
        DR_BSR:  TDO = bsr_sr_q[0];
        default: TDO = byp_q;
      endcase
    end
  end

  assign PIN_OUT   = (is_extest || is_clamp) ? bsr_upd_q : CORE_OUT;
  assign CORE_IN   = is_intest ? bsr_upd_q : PIN_IN;
  assign PIN_OE    = ~is_highz;
  assign JTAG_IR   = ir_q;
  assign TAP_STATE = state;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench: behavioural TAP model compared every cycle, directed
// scenarios pinned by literal values, then randomized scans and TMS walks.
module tb_jtag_tap_core;

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI;
  logic [7:0] PIN_IN, CORE_OUT;
  logic       TDO, TDO_EN, PIN_OE;
  logic [7:0] PIN_OUT, CORE_IN;
  logic [3:0] JTAG_IR, TAP_STATE;

  jtag_tap_core #(
    .IR_WIDTH     (4),
    .BSR_WIDTH    (8),
    .IDCODE_VAL   (32'h1000_0001),
    .USERCODE_VAL (32'h0000_0000)
  ) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .TDO_EN    (TDO_EN),
    .PIN_IN    (PIN_IN),
    .CORE_OUT  (CORE_OUT),
    .PIN_OUT   (PIN_OUT),
    .PIN_OE    (PIN_OE),
    .CORE_IN   (CORE_IN),
    .JTAG_IR   (JTAG_IR),
    .TAP_STATE (TAP_STATE)
  );

  always #5 TCK = ~TCK;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6,
                         S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR = 4'h3, S_E2DR = 4'h0,
                         S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA,
                         S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_st, m_ir, m_ir_sr;
  logic        m_byp;
  logic [31:0] m_id;
  logic [7:0]  m_bsr, m_upd;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void init_graph();
    // Standard TAP graph: {state, next on TMS=0, next on TMS=1}.
    logic [11:0] g [16] = '{
      {S_TLR, S_RTI, S_TLR},   {S_RTI, S_RTI, S_SDR},   {S_SDR, S_CDR, S_SIR},
      {S_CDR, S_SHDR, S_E1DR}, {S_SHDR, S_SHDR, S_E1DR}, {S_E1DR, S_PDR, S_UDR},
      {S_PDR, S_PDR, S_E2DR},  {S_E2DR, S_SHDR, S_UDR}, {S_UDR, S_RTI, S_SDR},
      {S_SIR, S_CIR, S_TLR},   {S_CIR, S_SHIR, S_E1IR}, {S_SHIR, S_SHIR, S_E1IR},
      {S_E1IR, S_PIR, S_UIR},  {S_PIR, S_PIR, S_E2IR},  {S_E2IR, S_SHIR, S_UIR},
      {S_UIR, S_RTI, S_SDR}};
    for (int i = 0; i < 16; i++) begin
      nxt0[g[i][11:8]] = g[i][7:4];
      nxt1[g[i][11:8]] = g[i][3:0];
    end
  endfunction

  // 0 = bypass, 1 = 32-bit id register, 2 = boundary scan
  function automatic int dr_kind(input logic [3:0] ir);
    case (ir)
      4'd7, 4'd8:       return 1;
      4'd1, 4'd2, 4'd3: return 2;
      default:          return 0;
    endcase
  endfunction

  task automatic model_step(input logic tms, input logic tdi);
    int k;
    if (!TRST) begin
      m_st = S_TLR; m_ir = 4'd7; m_ir_sr = '0;
      m_byp = 1'b0; m_id = '0; m_bsr = '0; m_upd = '0;
      return;
    end
    k = dr_kind(m_ir);
    case (m_st)
      S_CIR:  m_ir_sr = 4'd1;
      S_SHIR: m_ir_sr = (m_ir_sr >> 1) | (4'(tdi) << 3);
      S_UIR:  m_ir = m_ir_sr;
      S_CDR: begin
        m_byp = 1'b0;
        if (k == 1) m_id = (m_ir == 4'd7) ? 32'h1000_0001 : 32'h0;
        if (k == 2) m_bsr = (m_ir == 4'd3) ? CORE_OUT : PIN_IN;
      end
      S_SHDR: begin
        if (k == 0) m_byp = tdi;
        if (k == 1) m_id = (m_id >> 1) | (32'(tdi) << 31);
        if (k == 2) m_bsr = (m_bsr >> 1) | (8'(tdi) << 7);
      end
      S_UDR: if (k == 2) m_upd = m_bsr;
      default: ;
    endcase
    m_st = tms ? nxt1[m_st] : nxt0[m_st];
    if (m_st == S_TLR) m_ir = 4'd7;
  endtask

  task automatic compare();
    logic exp_tdo, exp_en;
    int k;
    exp_tdo = 1'b0;
    exp_en  = 1'b0;
    k = dr_kind(m_ir);
    if (m_st == S_SHIR) begin
      exp_en = 1'b1; exp_tdo = m_ir_sr[0];
    end else if (m_st == S_SHDR) begin
      exp_en = 1'b1;
      exp_tdo = (k == 1) ? m_id[0] : (k == 2) ? m_bsr[0] : m_byp;
    end
    check("tap_state", TAP_STATE, m_st);
    check("jtag_ir",   JTAG_IR, m_ir);
    check("tdo",       TDO, exp_tdo);
    check("tdo_en",    TDO_EN, exp_en);
    check("pin_out",   PIN_OUT, (m_ir == 4'd2 || m_ir == 4'd5) ? m_upd : CORE_OUT);
    check("core_in",   CORE_IN, (m_ir == 4'd3) ? m_upd : PIN_IN);
    check("pin_oe",    PIN_OE, m_ir != 4'd9);
  endtask

  // One TCK cycle: entered and left at the falling edge.
  task automatic tick(input logic tms, input logic tdi, output logic tdo_seen);
    TMS = tms;
    TDI = tdi;
    #1;
    if (m_valid) compare();
    tdo_seen = TDO;
    @(posedge TCK);
    model_step(tms, tdi);
    m_valid = 1'b1;
    @(negedge TCK);
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, input bit exit_last,
                            output logic [63:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tick(exit_last && (i == n - 1), din[i], b);
      dout[i] = b;
    end
  endtask

  // Scan helpers start and end in Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic t;
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    shift_bits(n, din, 1'b1, dout);
    tick(1, 0, t); tick(0, 0, t);
  endtask

  task automatic load_ir(input logic [3:0] op, output logic [3:0] captured);
    logic t;
    logic [63:0] d;
    tick(1, 0, t); tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    shift_bits(4, 64'(op), 1'b1, d);
    captured = d[3:0];
    tick(1, 0, t); tick(0, 0, t);
  endtask

  task automatic go_idle();
    logic t;
    for (int i = 0; i < 5; i++) tick(1, $urandom_range(0, 1), t);
    tick(0, 0, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        t;
    logic [3:0]  cap;
    logic [63:0] dout;
    logic [3:0]  ops [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9, 4'hF, 4'd6};

    init_graph();
    TRST = 1'b0; TMS = 1'b1; TDI = 1'b0;
    PIN_IN = 8'h00; CORE_OUT = 8'h00;
    @(negedge TCK);

    // Reset, then idle; IDCODE read back over 32 clocks.
    tick(1, 0, t);
    TRST = 1'b1;
    check("reset_state", TAP_STATE, 4'hF);
    check("reset_tdo_en", TDO_EN, 1'b0);
    check("reset_pin_oe", PIN_OE, 1'b1);
    tick(0, 0, t);
    check("idle_state", TAP_STATE, 4'hC);
    check("idle_ir", JTAG_IR, 4'd7);
    dr_scan(32, 64'h0, dout);
    check("idcode_read", dout[31:0], 32'h1000_0001);

    // Five TMS=1 edges from Shift-DR reach Test-Logic-Reset; a sixth holds it.
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    check("in_shift_dr", TAP_STATE, 4'h2);
    for (int i = 0; i < 5; i++) tick(1, 0, t);
    check("tms_reset_5", TAP_STATE, 4'hF);
    tick(1, 0, t);
    check("tms_reset_6", TAP_STATE, 4'hF);
    tick(0, 0, t);

    // BYPASS delays the pattern by one clock behind a captured 0.
    load_ir(4'hF, cap);
    dr_scan(8, 64'hB2, dout);
    check("bypass_delay", dout[7:0], 8'h64);

    // IR capture pattern shifts out LSB first.
    tick(1, 0, t); tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    shift_bits(4, 64'hF, 1'b1, dout);
    tick(1, 0, t);
    tick(0, 0, t);
    check("ir_capture", dout[3:0], 4'b0001);
    check("ir_bypass", JTAG_IR, 4'hF);

    // EXTEST drives the pads from the update stage; HIGHZ releases them.
    CORE_OUT = 8'h3C; PIN_IN = 8'h11;
    load_ir(4'd2, cap);
    dr_scan(8, 64'hA5, dout);
    check("extest_sample", dout[7:0], 8'h11);
    check("extest_pin_out", PIN_OUT, 8'hA5);
    load_ir(4'd9, cap);
    check("highz_oe", PIN_OE, 1'b0);
    check("highz_pin_out", PIN_OUT, 8'h3C);

    // INTEST captures core outputs and drives core inputs.
    CORE_OUT = 8'h5A;
    load_ir(4'd3, cap);
    dr_scan(8, 64'hC3, dout);
    check("intest_capture", dout[7:0], 8'h5A);
    check("intest_core_in", CORE_IN, 8'hC3);

    // TRST in the middle of a scan discards it.
    load_ir(4'd2, cap);
    tick(1, 0, t); tick(0, 0, t); tick(0, 0, t);
    shift_bits(4, 64'hC3, 1'b0, dout);
    CORE_OUT = 8'h96;
    TRST = 1'b0;
    tick(0, 0, t);
    TRST = 1'b1;
    check("trst_state", TAP_STATE, 4'hF);
    check("trst_ir", JTAG_IR, 4'd7);
    check("trst_pin_out", PIN_OUT, 8'h96);
    tick(0, 0, t);
    load_ir(4'd2, cap);
    check("trst_no_update", PIN_OUT, 8'h00);

    // Randomized traffic checked against the model every cycle.
    for (int it = 0; it < 150; it++) begin
      PIN_IN   = 8'($urandom);
      CORE_OUT = 8'($urandom);
      case ($urandom_range(0, 4))
        0: load_ir(($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 8)], cap);
        1, 2: dr_scan($urandom_range(1, 40), {$urandom, $urandom}, dout);
        3: begin
          for (int j = 0; j < 12; j++) begin
            TRST = ($urandom_range(0, 15) != 0);
            tick($urandom_range(0, 1), $urandom_range(0, 1), t);
          end
          TRST = 1'b1;
          go_idle();
        end
        default: tick(0, $urandom_range(0, 1), t);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
